down_count_monitor: RTL and testbench



---
 rtl/down_count_monitor.sv | 100 ++++++++++
 tb/tb_down_count_monitor.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/down_count_monitor.sv
// Monitors a free-running down counter. It checks that the count steps down by one each cycle
// and emits registered terminal-count, wrap and compare-match pulses.
module down_count_monitor #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned EPOCH_W    = 8,
  parameter int unsigned ALLOW_HOLD = 0
) (
  input  logic               clock0,
  input  logic               reset,
  input  logic [WIDTH-1:0]   count_in,
  input  logic [WIDTH-1:0]   cmp_value,
  input  logic               clear_err,
  output logic               tc_pulse,
  output logic               wrap_pulse,
  output logic               match_pulse,
  output logic [EPOCH_W-1:0] epoch,
  output logic               err,
  output logic               tracking
);

  typedef enum logic [1:0] {StIdle, StTrack, StError} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   prev_q;
  logic [WIDTH-1:0]   expected;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               err_q, err_d;
  logic               tc_q, tc_d;
  logic               wrap_q, wrap_d;
  logic               match_q, match_d;

  // Modulo subtraction, so prev == 0 expects all-ones.
  assign expected = prev_q - WIDTH'(1);

  always_comb begin
    state_d = state_q;
    epoch_d = epoch_q;
    err_d   = err_q;
    tc_d    = 1'b0;
    wrap_d  = 1'b0;
    match_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        tc_d    = (count_in == '0);
        match_d = (count_in == cmp_value);
        state_d = StTrack;
      end
      StTrack: begin
        if (count_in == expected) begin
          tc_d    = (count_in == '0);
          match_d = (count_in == cmp_value);
          wrap_d  = (prev_q == '0);
          if ((prev_q == '0) && (epoch_q != '1)) begin
            epoch_d = epoch_q + EPOCH_W'(1);
          end
        end else if ((count_in == prev_q) && (ALLOW_HOLD != 0)) begin
          state_d = StTrack;
        end else begin
          err_d   = 1'b1;
          state_d = StError;
        end
      end
      StError: begin
        if (clear_err) begin
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock0) begin
    if (reset) begin
      state_q <= StIdle;
      prev_q  <= '0;
      epoch_q <= '0;
      err_q   <= 1'b0;
      tc_q    <= 1'b0;
      wrap_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= count_in;
      epoch_q <= epoch_d;
      err_q   <= err_d;
      tc_q    <= tc_d;
      wrap_q  <= wrap_d;
      match_q <= match_d;
    end
  end

  assign tc_pulse    = tc_q;
  assign wrap_pulse  = wrap_q;
  assign match_pulse = match_q;
  assign epoch       = epoch_q;
  assign err         = err_q;
  assign tracking    = (state_q == StTrack);

endmodule

// File: tb/tb_down_count_monitor.sv
// Directed bench for down_count_monitor: a default instance, a hold-tolerant instance and a
// narrow instance with a 2-bit epoch, all driven from the same stimulus.
module tb_down_count_monitor;

  logic        clock0 = 1'b0;
  logic        reset;
  logic [15:0] count_in;
  logic [15:0] cmp_value;
  logic        clear_err;

  logic       tc, wrap, match, err, trk;
  logic [7:0] ep;
  logic       h_tc, h_wrap, h_match, h_err, h_trk;
  logic [7:0] h_ep;
  logic       e_tc, e_wrap, e_match, e_err, e_trk;
  logic [1:0] e_ep;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock0 = ~clock0;

  down_count_monitor dut (
    .clock0(clock0), .reset(reset), .count_in(count_in), .cmp_value(cmp_value),
    .clear_err(clear_err), .tc_pulse(tc), .wrap_pulse(wrap), .match_pulse(match),
    .epoch(ep), .err(err), .tracking(trk)
  );

  down_count_monitor #(.ALLOW_HOLD(1)) dut_h (
    .clock0(clock0), .reset(reset), .count_in(count_in), .cmp_value(cmp_value),
    .clear_err(clear_err), .tc_pulse(h_tc), .wrap_pulse(h_wrap), .match_pulse(h_match),
    .epoch(h_ep), .err(h_err), .tracking(h_trk)
  );

  down_count_monitor #(.WIDTH(4), .EPOCH_W(2)) dut_e (
    .clock0(clock0), .reset(reset), .count_in(count_in[3:0]), .cmp_value(cmp_value[3:0]),
    .clear_err(clear_err), .tc_pulse(e_tc), .wrap_pulse(e_wrap), .match_pulse(e_match),
    .epoch(e_ep), .err(e_err), .tracking(e_trk)
  );

  typedef struct {
    logic        rst;
    logic        clr;
    logic [15:0] cnt;
    logic [15:0] cmp;
    logic [12:0] exp; // {tc, wrap, match, err, tracking, epoch}
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic clr, input logic [15:0] cnt,
                     input logic [15:0] cmp, input logic [12:0] exp);
    vec_t v;
    v.rst = rst; v.clr = clr; v.cnt = cnt; v.cmp = cmp; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic step(input logic rst, input logic clr, input logic [15:0] cnt,
                      input logic [15:0] cmp);
    reset     = rst;
    clear_err = clr;
    count_in  = cnt;
    cmp_value = cmp;
    @(posedge clock0);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  initial begin
    reset = 1'b1; clear_err = 1'b0; count_in = '0; cmp_value = '0;

    //   rst   clr   count      cmp        {tc,wr,ma,er,tk,epoch}
    add(1'b1, 1'b0, 16'h0000, 16'h1234, {5'b00000, 8'd0}); // reset state
    add(1'b0, 1'b0, 16'hFFFF, 16'hFFFE, {5'b00001, 8'd0}); // idle capture
    add(1'b0, 1'b0, 16'hFFFE, 16'hFFFE, {5'b00101, 8'd0}); // match
    add(1'b0, 1'b0, 16'hFFFD, 16'hFFFE, {5'b00001, 8'd0});
    add(1'b1, 1'b0, 16'h0000, 16'h1234, {5'b00000, 8'd0});
    add(1'b0, 1'b0, 16'h0002, 16'h1234, {5'b00001, 8'd0});
    add(1'b0, 1'b0, 16'h0001, 16'h1234, {5'b00001, 8'd0});
    add(1'b0, 1'b0, 16'h0000, 16'h0000, {5'b10101, 8'd0}); // tc + match
    add(1'b0, 1'b0, 16'hFFFF, 16'hFFFF, {5'b01101, 8'd1}); // wrap + match
    add(1'b0, 1'b0, 16'hFFFE, 16'h1234, {5'b00001, 8'd1});
    add(1'b0, 1'b0, 16'h0010, 16'h1234, {5'b00010, 8'd1}); // jump -> error
    add(1'b0, 1'b1, 16'h0010, 16'h1234, {5'b00000, 8'd1}); // clear -> idle
    add(1'b0, 1'b0, 16'h000F, 16'h000F, {5'b00101, 8'd1}); // idle sample matches
    add(1'b0, 1'b0, 16'h000D, 16'h1234, {5'b00010, 8'd1}); // skipped 0x000E
    add(1'b0, 1'b0, 16'h000C, 16'h000C, {5'b00010, 8'd1}); // pulses suppressed
    add(1'b0, 1'b0, 16'h0000, 16'h0000, {5'b00010, 8'd1});
    add(1'b0, 1'b1, 16'h0005, 16'h1234, {5'b00000, 8'd1});
    add(1'b0, 1'b0, 16'h0004, 16'h1234, {5'b00001, 8'd1});
    add(1'b0, 1'b0, 16'h0003, 16'h0003, {5'b00101, 8'd1});
    add(1'b0, 1'b0, 16'h0002, 16'h1234, {5'b00001, 8'd1});

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].clr, tbl[i].cnt, tbl[i].cmp);
      chk($sformatf("vec%0d", i), {19'd0, tc, wrap, match, err, trk, ep}, {19'd0, tbl[i].exp});
    end

    // Hold behaviour with and without ALLOW_HOLD
    step(1'b1, 1'b0, 16'h0000, 16'h0100);
    step(1'b0, 1'b0, 16'h0100, 16'h0100);
    step(1'b0, 1'b0, 16'h0100, 16'h0100);
    chk("hold_strict", {27'd0, tc, wrap, match, err, trk}, {27'd0, 5'b00010});
    chk("hold_allowed", {27'd0, h_tc, h_wrap, h_match, h_err, h_trk}, {27'd0, 5'b00001});
    step(1'b0, 1'b0, 16'h00FF, 16'h0100);
    chk("hold_resume", {27'd0, h_tc, h_wrap, h_match, h_err, h_trk}, {27'd0, 5'b00001});

    // Four wraps of the 4-bit instance; epoch saturates at 3
    step(1'b1, 1'b0, 16'h0000, 16'h0000);
    for (int i = 0; i <= 66; i++) begin
      logic [3:0] c;
      logic       x_tc, x_wrap;
      logic [1:0] x_ep;
      c      = 4'(15 - (i % 16));
      x_tc   = (c == 4'd0);
      x_wrap = (i > 0) && (i % 16 == 0);
      x_ep   = (i / 16 > 3) ? 2'd3 : 2'(i / 16);
      step(1'b0, 1'b0, {12'h000, c}, 16'h0000);
      chk($sformatf("epoch_seq%0d", i), {27'd0, e_tc, e_wrap, e_match, e_ep},
          {27'd0, x_tc, x_wrap, x_tc, x_ep});
    end
    chk("epoch_no_err", {31'd0, e_err}, 32'd0);
    chk("main_in_error", {31'd0, err}, 32'd1);

    // Reset wins over a simultaneous clear_err
    step(1'b1, 1'b1, 16'h0007, 16'h0007);
    chk("rst_clr_main", {19'd0, tc, wrap, match, err, trk, ep}, 32'd0);
    chk("rst_clr_epoch", {27'd0, e_tc, e_wrap, e_match, e_ep}, 32'd0);
    chk("rst_clr_hold", {27'd0, h_tc, h_wrap, h_match, h_err, h_trk}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
